seven_seg_serial_scanner: RTL and testbench

//  Parametrised successor of the single-pair serial 7-seg driver: scans NUM_DIGITS digits

---
 rtl/seven_seg_pkg.sv | 25 ++
 rtl/seven_seg_frame_builder.sv | 21 ++
 rtl/seven_seg_serial_scanner.sv | 170 +++++++++++++++++
 tb/tb_seven_seg_serial_scanner.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the serial seven-segment scanner: glyph table, digit select codes
// and the scan FSM state type.
package seven_seg_pkg;

  localparam int FRAME_W = 16;

  // Segment patterns for hex 0..F as wired on the display header (bit 0 is the dp)
  localparam logic [7:0] GLYPH [16] = '{
    8'hEE, 8'h48, 8'h3E, 8'h7C, 8'hD8, 8'hF4, 8'hF6, 8'h68,
    8'hFE, 8'hFC, 8'hFA, 8'hD6, 8'hA6, 8'h5E, 8'hB6, 8'hB2
  };

  localparam logic [7:0] DIGIT_SEL [8] = '{
    8'h40, 8'h20, 8'h08, 8'h04, 8'h80, 8'h10, 8'h02, 8'h01
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_GAP
  } state_t;

endpackage

// File: rtl/seven_seg_frame_builder.sv
// Combinational frame assembly for one digit: {SEG, SEL}, SEL shifted out first.
import seven_seg_pkg::*;

module seven_seg_frame_builder (
  input  logic [3:0]         nibble,
  input  logic               dp,
  input  logic               blank,
  input  logic [2:0]         digit,
  output logic [FRAME_W-1:0] frame
);

  logic [7:0] seg;

  // Blanking only clears the glyph; the decimal point stays visible
  always_comb begin
    seg    = blank ? 8'h00 : GLYPH[nibble];
    seg[0] = seg[0] | dp;
    frame  = {seg, DIGIT_SEL[digit]};
  end

endmodule

// File: rtl/seven_seg_serial_scanner.sv
// Scans NUM_DIGITS hex digits into a 74HC595-style chain, one 16-bit frame per digit,
// generating its own shift clock and latch strobe.
import seven_seg_pkg::*;

module seven_seg_serial_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCLK_DIV    = 4,
  parameter int REFRESH_GAP = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic                    sclk,
  output logic                    sdata,
  output logic                    latch,
  output logic                    frame_done
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (2 * SCLK_DIV > REFRESH_GAP) ? 2 * SCLK_DIV : REFRESH_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] FD_AT      = CNT_W'(2 * SCLK_DIV - 2);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((REFRESH_GAP > 0) ? REFRESH_GAP - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W - 1);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        next_idx;
  logic [CNT_W-1:0]        cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [FRAME_W-2:0]      shreg;
  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    shadow_blank;

  logic [4*NUM_DIGITS-1:0] src_data;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic [3:0]              nibble;
  logic                    higher_zero;
  logic                    blank;
  logic [FRAME_W-1:0]      frame;

  // Digit 0 is built from the live inputs because the shadow is captured on that same edge
  always_comb begin
    src_data    = (idx == '0) ? data_in : shadow_data;
    src_dp      = (idx == '0) ? dp_in : shadow_dp;
    nibble      = src_data[{idx, 2'b00} +: 4];
    higher_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx) && shadow_data[4*j +: 4] != 4'h0) higher_zero = 1'b0;
    end
    blank    = shadow_blank && (idx != '0) && higher_zero;
    next_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  end

  seven_seg_frame_builder u_frame_builder (
    .nibble (nibble),
    .dp     (src_dp[idx]),
    .blank  (blank),
    .digit  (3'(idx)),
    .frame  (frame)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sclk         <= 1'b0;
      sdata        <= 1'b0;
      latch        <= 1'b0;
      frame_done   <= 1'b0;
      idx          <= '0;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          sclk       <= 1'b0;
          sdata      <= 1'b0;
          latch      <= 1'b0;
          frame_done <= 1'b0;
          idx        <= '0;
          cnt        <= '0;
          if (enable) state <= S_LOAD;
        end
        S_LOAD: begin
          if (idx == '0) begin
            shadow_data  <= data_in;
            shadow_dp    <= dp_in;
            shadow_blank <= blank_lz;
          end
          sdata   <= frame[0];
          shreg   <= frame[FRAME_W-1:1];
          sclk    <= 1'b0;
          cnt     <= '0;
          bit_cnt <= '0;
          state   <= S_SHIFT;
        end
        // Each bit: sclk low half (data settles), then high half; data advances on the fall
        S_SHIFT: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                latch <= 1'b1;
                state <= S_LATCH;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                sdata   <= shreg[0];
                shreg   <= {1'b0, shreg[FRAME_W-2:1]};
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LATCH: begin
          if (cnt == LATCH_LAST) begin
            latch      <= 1'b0;
            frame_done <= 1'b0;
            sdata      <= 1'b0;
            cnt        <= '0;
            if (REFRESH_GAP > 0) begin
              idx   <= next_idx;
              state <= S_GAP;
            end else if (enable) begin
              idx   <= next_idx;
              state <= S_LOAD;
            end else begin
              idx   <= '0;
              state <= S_IDLE;
            end
          end else begin
            cnt        <= cnt + 1'b1;
            frame_done <= (cnt == FD_AT);
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (enable) begin
              state <= S_LOAD;
            end else begin
              idx   <= '0;
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_serial_scanner.sv
// Bench for seven_seg_serial_scanner: three configurations, frames recovered from the serial
// pins and compared against a table-driven model of the display.
module tb_seven_seg_serial_scanner;

  localparam int ND [3] = '{4, 8, 1};
  localparam int SD [3] = '{1, 2, 3};
  localparam int GP [3] = '{5, 0, 2};

  localparam logic [7:0] GLYPH_TB [16] = '{
    8'hEE, 8'h48, 8'h3E, 8'h7C, 8'hD8, 8'hF4, 8'hF6, 8'h68,
    8'hFE, 8'hFC, 8'hFA, 8'hD6, 8'hA6, 8'h5E, 8'hB6, 8'hB2
  };
  localparam logic [7:0] SEL_TB [8] = '{8'h40, 8'h20, 8'h08, 8'h04, 8'h80, 8'h10, 8'h02, 8'h01};

  logic        clk;
  logic        rst_n;
  logic [2:0]  en;
  logic [2:0]  blz;
  logic [15:0] data_a;
  logic [3:0]  dp_a;
  logic [31:0] data_b;
  logic [7:0]  dp_b;
  logic [3:0]  data_c;
  logic        dp_c;
  wire  [2:0]  sclk_v, sdata_v, latch_v, fd_v;

  int checks, errors, cyc;
  logic [15:0] frames   [3][$];
  int          nbits    [3][$];
  int          rise_cyc [3][$];
  int          lat_len  [3][$];
  int          fd_pos   [3][$];
  int          fd_cnt [3];
  int          nb [3];
  int          lat_run [3];
  int          sclk_in_latch [3];
  logic [15:0] cur [3];
  logic [2:0]  prev_sclk, prev_latch;

  seven_seg_serial_scanner #(.NUM_DIGITS(ND[0]), .SCLK_DIV(SD[0]), .REFRESH_GAP(GP[0])) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_a), .dp_in(dp_a), .blank_lz(blz[0]), .enable(en[0]),
    .sclk(sclk_v[0]), .sdata(sdata_v[0]), .latch(latch_v[0]), .frame_done(fd_v[0]));

  seven_seg_serial_scanner #(.NUM_DIGITS(ND[1]), .SCLK_DIV(SD[1]), .REFRESH_GAP(GP[1])) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_b), .dp_in(dp_b), .blank_lz(blz[1]), .enable(en[1]),
    .sclk(sclk_v[1]), .sdata(sdata_v[1]), .latch(latch_v[1]), .frame_done(fd_v[1]));

  seven_seg_serial_scanner #(.NUM_DIGITS(ND[2]), .SCLK_DIV(SD[2]), .REFRESH_GAP(GP[2])) dut_c (
    .clk(clk), .rst_n(rst_n), .data_in(data_c), .dp_in(dp_c), .blank_lz(blz[2]), .enable(en[2]),
    .sclk(sclk_v[2]), .sdata(sdata_v[2]), .latch(latch_v[2]), .frame_done(fd_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What the display should receive for digit k, straight from the glyph/select tables
  function automatic logic [15:0] model_frame(int k, logic [31:0] data, logic [7:0] dp, logic b);
    logic [7:0] seg;
    int nib, upper;
    nib   = int'((data >> (4 * k)) & 32'hF);
    upper = int'(data >> (4 * k));
    seg   = (b && k > 0 && upper == 0) ? 8'h00 : GLYPH_TB[nib];
    if (dp[k]) seg = seg | 8'h01;
    return {seg, SEL_TB[k]};
  endfunction

  function automatic int period(int d);
    return 1 + 34 * SD[d] + GP[d];
  endfunction

  // Recover frames from the chain pins the way a shift register would see them
  initial begin
    cyc = 0;
    prev_sclk = '0;
    prev_latch = '0;
    for (int d = 0; d < 3; d++) begin
      fd_cnt[d] = 0; nb[d] = 0; lat_run[d] = 0; sclk_in_latch[d] = 0; cur[d] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 3; d++) begin
        if (!rst_n) begin
          nb[d] = 0; lat_run[d] = 0; cur[d] = '0; prev_sclk[d] = 1'b0; prev_latch[d] = 1'b0;
        end else begin
          if (latch_v[d] && !prev_latch[d]) begin
            frames[d].push_back(cur[d]);
            nbits[d].push_back(nb[d]);
            rise_cyc[d].push_back(cyc);
            nb[d] = 0;
            lat_run[d] = 0;
          end
          if (sclk_v[d] && !prev_sclk[d]) begin
            cur[d] = {sdata_v[d], cur[d][15:1]};
            nb[d]++;
          end
          if (latch_v[d]) lat_run[d]++;
          if (latch_v[d] && sclk_v[d]) sclk_in_latch[d]++;
          if (!latch_v[d] && prev_latch[d]) lat_len[d].push_back(lat_run[d]);
          if (fd_v[d]) begin
            fd_cnt[d]++;
            fd_pos[d].push_back(latch_v[d] ? lat_run[d] : -1);
          end
          prev_sclk[d]  = sclk_v[d];
          prev_latch[d] = latch_v[d];
        end
      end
    end
  end

  task automatic mon_clear(input int d);
    frames[d].delete(); nbits[d].delete(); rise_cyc[d].delete();
    lat_len[d].delete(); fd_pos[d].delete();
    fd_cnt[d] = 0;
    sclk_in_latch[d] = 0;
  endtask

  task automatic set_inputs(input int d, input logic [31:0] data, input logic [7:0] dp, input logic b);
    case (d)
      0: begin data_a = data[15:0]; dp_a = dp[3:0]; end
      1: begin data_b = data; dp_b = dp; end
      default: begin data_c = data[3:0]; dp_c = dp[0]; end
    endcase
    blz[d] = b;
  endtask

  task automatic rand_inputs(input int nd, output logic [31:0] data, output logic [7:0] dp, output logic b);
    data = '0;
    dp   = '0;
    for (int i = 0; i < nd; i++) begin
      data[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      dp[i] = 1'($urandom_range(0, 1));
    end
    b = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_frames(input int d, input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && frames[d].size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    ok = (frames[d].size() >= n);
  endtask

  task automatic go_idle(input int d);
    en[d] = 1'b0;
    repeat (2 * period(d) + 10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit ok;
    logic [3:0] outs;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      outs = {sclk_v[d], sdata_v[d], latch_v[d], fd_v[d]};
      checks++;
      if (outs !== 4'b0000) begin
        errors++; $display("[TB] FAIL reset_outputs dut%0d: got %b expected 0000", d, outs);
      end
    end
    rst_n = 1'b1;
    set_inputs(0, 32'h0000_8888, 8'h0F, 1'b0);
    en[0] = 1'b1;
    for (int i = 0; i < 200 && !(nb[0] >= 3 && sclk_v[0]); i++) begin @(posedge clk); #1; end
    checks++;
    if (!(nb[0] >= 3 && sclk_v[0])) begin
      errors++; $display("[TB] FAIL reset_reach_shift: got bits=%0d expected >=3 with sclk high", nb[0]);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    outs = {sclk_v[0], sdata_v[0], latch_v[0], fd_v[0]};
    checks++;
    if (outs !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_mid_shift: got %b expected 0000", outs);
    end
    repeat (2) @(posedge clk);
    #1;
    mon_clear(0);
    rst_n = 1'b1;
    wait_frames(0, 1, 3 * period(0), ok);
    checks++;
    if (!ok || frames[0][0] !== model_frame(0, 32'h8888, 8'h0F, 1'b0) || nbits[0][0] != 16) begin
      errors++;
      $display("[TB] FAIL reset_resume_digit0: got %h (%0d bits) expected %h (16 bits)",
               ok ? frames[0][0] : 16'hxxxx, ok ? nbits[0][0] : 0, model_frame(0, 32'h8888, 8'h0F, 1'b0));
    end
    go_idle(0);
  endtask

  task automatic test_pattern();
    bit ok;
    mon_clear(0);
    set_inputs(0, 32'h1234, 8'h00, 1'b0);
    en[0] = 1'b1;
    wait_frames(0, 5, 7 * period(0), ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL pattern_frames: got %0d frames expected 5", frames[0].size());
    end else begin
      checks++;
      if (frames[0][0] !== 16'hD840) begin
        errors++; $display("[TB] FAIL pattern_digit0: got %h expected d840", frames[0][0]);
      end
      checks++;
      if (frames[0][3] !== 16'h4804) begin
        errors++; $display("[TB] FAIL pattern_digit3: got %h expected 4804", frames[0][3]);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (frames[0][i] !== model_frame(i, 32'h1234, 8'h00, 1'b0)) begin
          errors++; $display("[TB] FAIL pattern_frame%0d: got %h expected %h", i, frames[0][i],
                             model_frame(i, 32'h1234, 8'h00, 1'b0));
        end
        checks++;
        if (nbits[0][i] != 16 || lat_len[0][i] != 2 || fd_pos[0][i] != 2) begin
          errors++; $display("[TB] FAIL pattern_shape%0d: got bits=%0d latch=%0d fd_at=%0d expected 16/2/2",
                             i, nbits[0][i], lat_len[0][i], fd_pos[0][i]);
        end
        checks++;
        if (rise_cyc[0][i+1] - rise_cyc[0][i] != period(0)) begin
          errors++; $display("[TB] FAIL pattern_period%0d: got %0d expected %0d", i,
                             rise_cyc[0][i+1] - rise_cyc[0][i], period(0));
        end
      end
      checks++;
      if (sclk_in_latch[0] != 0) begin
        errors++; $display("[TB] FAIL pattern_sclk_in_latch: got %0d expected 0", sclk_in_latch[0]);
      end
    end
    go_idle(0);
  endtask

  task automatic test_blanking();
    bit ok;
    logic [7:0] exp_seg [4];
    exp_seg = '{8'hEE, 8'h68, 8'h00, 8'h01};
    mon_clear(0);
    set_inputs(0, 32'h0070, 8'b1000, 1'b1);
    en[0] = 1'b1;
    wait_frames(0, 4, 6 * period(0), ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL blank_frames: got %0d frames expected 4", frames[0].size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (frames[0][i] !== {exp_seg[i], SEL_TB[i]}) begin
          errors++; $display("[TB] FAIL blank_digit%0d: got %h expected %h", i, frames[0][i],
                             {exp_seg[i], SEL_TB[i]});
        end
      end
    end
    go_idle(0);
  endtask

  task automatic test_random_passes();
    bit ok;
    logic [31:0] pd [6];
    logic [7:0]  pp [6];
    logic        pb [6];
    logic [15:0] exp;
    mon_clear(0);
    for (int p = 0; p < 6; p++) rand_inputs(ND[0], pd[p], pp[p], pb[p]);
    set_inputs(0, pd[0], pp[0], pb[0]);
    en[0] = 1'b1;
    ok = 1'b1;
    for (int p = 0; p < 6 && ok; p++) begin
      wait_frames(0, 4 * (p + 1), 6 * period(0), ok);
      if (ok && p < 5) set_inputs(0, pd[p+1], pp[p+1], pb[p+1]);
    end
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL random_frames: got %0d frames expected 24", frames[0].size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        exp = model_frame(i % 4, pd[i/4], pp[i/4], pb[i/4]);
        checks++;
        if (frames[0][i] !== exp) begin
          errors++; $display("[TB] FAIL random_frame%0d: got %h expected %h", i, frames[0][i], exp);
        end
      end
    end
    go_idle(0);
  endtask

  task automatic test_snapshot();
    bit ok;
    logic [15:0] exp;
    mon_clear(0);
    set_inputs(0, 32'h1111, 8'h00, 1'b0);
    en[0] = 1'b1;
    wait_frames(0, 2, 4 * period(0), ok);
    repeat (15) @(posedge clk);
    #1;
    set_inputs(0, 32'h2222, 8'h00, 1'b0);
    wait_frames(0, 8, 10 * period(0), ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL snapshot_frames: got %0d frames expected 8", frames[0].size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp = model_frame(i % 4, (i < 4) ? 32'h1111 : 32'h2222, 8'h00, 1'b0);
        checks++;
        if (frames[0][i] !== exp) begin
          errors++; $display("[TB] FAIL snapshot_frame%0d: got %h expected %h", i, frames[0][i], exp);
        end
      end
    end
    go_idle(0);
  endtask

  task automatic test_enable_drop();
    bit ok;
    logic [31:0] data;
    logic [7:0]  dp;
    logic        b;
    logic [3:0]  outs;
    rand_inputs(ND[0], data, dp, b);
    mon_clear(0);
    set_inputs(0, data, dp, b);
    en[0] = 1'b1;
    wait_frames(0, 1, 3 * period(0), ok);
    for (int i = 0; i < 3 * period(0) && nb[0] < 5; i++) begin @(posedge clk); #1; end
    en[0] = 1'b0;
    wait_frames(0, 2, 2 * period(0), ok);
    checks++;
    if (!ok || frames[0][1] !== model_frame(1, data, dp, b) || nbits[0][1] != 16) begin
      errors++; $display("[TB] FAIL drop_completes_digit1: got %h expected %h",
                         ok ? frames[0][1] : 16'hxxxx, model_frame(1, data, dp, b));
    end
    repeat (3 * period(0)) @(posedge clk);
    #1;
    outs = {sclk_v[0], sdata_v[0], latch_v[0], fd_v[0]};
    checks++;
    if (frames[0].size() != 2 || fd_cnt[0] != 2 || outs !== 4'b0000) begin
      errors++; $display("[TB] FAIL drop_goes_idle: got frames=%0d done=%0d outs=%b expected 2/2/0000",
                         frames[0].size(), fd_cnt[0], outs);
    end
    en[0] = 1'b1;
    wait_frames(0, 4, 4 * period(0), ok);
    checks++;
    if (!ok || frames[0][2] !== model_frame(0, data, dp, b)) begin
      errors++; $display("[TB] FAIL drop_restart_digit0: got %h expected %h",
                         ok ? frames[0][2] : 16'hxxxx, model_frame(0, data, dp, b));
    end
    en[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    en[0] = 1'b1;
    wait_frames(0, 5, 3 * period(0), ok);
    checks++;
    if (!ok || frames[0][4] !== model_frame(2, data, dp, b) || rise_cyc[0][4] - rise_cyc[0][3] != period(0)) begin
      errors++; $display("[TB] FAIL gap_reenable_continues: got %h expected %h",
                         ok ? frames[0][4] : 16'hxxxx, model_frame(2, data, dp, b));
    end
    go_idle(0);
  endtask

  task automatic test_num_digits();
    bit ok;
    int nf;
    logic [31:0] data;
    logic [7:0]  dp;
    logic        b;
    logic [15:0] exp;
    for (int d = 1; d < 3; d++) begin
      nf = (d == 1) ? 16 : 3;
      rand_inputs(ND[d], data, dp, b);
      mon_clear(d);
      set_inputs(d, data, dp, b);
      en[d] = 1'b1;
      wait_frames(d, nf + 1, (nf + 3) * period(d), ok);
      checks++;
      if (!ok) begin
        errors++; $display("[TB] FAIL digits%0d_frames: got %0d expected %0d", ND[d], frames[d].size(), nf + 1);
      end else begin
        for (int i = 0; i < nf; i++) begin
          exp = model_frame(i % ND[d], data, dp, b);
          checks++;
          if (frames[d][i] !== exp) begin
            errors++; $display("[TB] FAIL digits%0d_frame%0d: got %h expected %h", ND[d], i, frames[d][i], exp);
          end
          checks++;
          if (nbits[d][i] != 16 || lat_len[d][i] != 2 * SD[d] || fd_pos[d][i] != 2 * SD[d] ||
              rise_cyc[d][i+1] - rise_cyc[d][i] != period(d)) begin
            errors++; $display("[TB] FAIL digits%0d_shape%0d: got bits=%0d latch=%0d fd_at=%0d period=%0d expected 16/%0d/%0d/%0d",
                               ND[d], i, nbits[d][i], lat_len[d][i], fd_pos[d][i],
                               rise_cyc[d][i+1] - rise_cyc[d][i], 2 * SD[d], 2 * SD[d], period(d));
          end
        end
      end
      go_idle(d);
      checks++;
      if (fd_cnt[d] != frames[d].size()) begin
        errors++; $display("[TB] FAIL digits%0d_done_count: got %0d expected %0d", ND[d], fd_cnt[d], frames[d].size());
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    en     = '0;
    blz    = '0;
    data_a = '0; dp_a = '0; data_b = '0; dp_b = '0; data_c = '0; dp_c = 1'b0;
    test_reset();
    test_pattern();
    test_blanking();
    test_random_passes();
    test_snapshot();
    test_enable_drop();
    test_num_digits();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected test sequence to end");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
